// File: rtl/core_pkg.sv
// Shared types for the RV32I core pipeline control blocks.
package core_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Per-stage shadow of the fields hazard detection cares about.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             load;
  } stage_shadow_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand; MEM result beats WB result, x0 never forwards.
module hazard_fwd_sel
  import core_pkg::*;
(
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic             regwrite_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             regwrite_w,
  output fwd_sel_t         sel
);

  // Priority compare against MEM then WB destination.
  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs_e))
      sel = FWD_MEM;
    else if (regwrite_w && (rd_w != '0) && (rd_w == rs_e))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: forwarding selects, stall/flush
// generation and saturating event counters. Tracks E/M/W itself from D inputs.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_d,
  input  logic             regwrite_d,
  input  logic             load_d,
  input  logic             pcsrc_e,
  input  logic             mem_busy,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             stall_emw,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_shadow_t    sh_e_q, sh_e_d, sh_m_q, sh_m_d, sh_w_q, sh_w_d;
  logic [REG_W-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             lu;
  fwd_sel_t         fwd_a, fwd_b;

  assign lu = sh_e_q.load && (sh_e_q.rd != '0) &&
              ((sh_e_q.rd == rs1_d) || (sh_e_q.rd == rs2_d));

  // Control priority: memory freeze, then taken branch, then load-use.
  // Gated by rst_n so the controls drop the instant reset asserts.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    stall_emw = 1'b0;
    if (!rst_n) begin
      stall_f = 1'b0;
    end else if (mem_busy) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_emw = 1'b1;
    end else if (pcsrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Shadow pipeline advance and saturating event counts.
  always_comb begin
    sh_e_d      = sh_e_q;
    sh_m_d      = sh_m_q;
    sh_w_d      = sh_w_q;
    rs1_e_d     = rs1_e_q;
    rs2_e_d     = rs2_e_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!stall_emw) begin
      if (flush_e) begin
        sh_e_d  = '0;
        rs1_e_d = '0;
        rs2_e_d = '0;
      end else begin
        sh_e_d  = '{rd: rd_d, regwrite: regwrite_d, load: load_d};
        rs1_e_d = rs1_d;
        rs2_e_d = rs2_d;
      end
      // M and W only need the writeback destination.
      sh_m_d = '{rd: sh_e_q.rd, regwrite: sh_e_q.regwrite, load: 1'b0};
      sh_w_d = '{rd: sh_m_q.rd, regwrite: sh_m_q.regwrite, load: 1'b0};
      if (pcsrc_e) begin
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else if (lu) begin
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_e_q      <= '0;
      sh_m_q      <= '0;
      sh_w_q      <= '0;
      rs1_e_q     <= '0;
      rs2_e_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sh_e_q      <= sh_e_d;
      sh_m_q      <= sh_m_d;
      sh_w_q      <= sh_w_d;
      rs1_e_q     <= rs1_e_d;
      rs2_e_q     <= rs2_e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  hazard_fwd_sel u_fwd_a (
    .rs_e       (rs1_e_q),
    .rd_m       (sh_m_q.rd),
    .regwrite_m (sh_m_q.regwrite),
    .rd_w       (sh_w_q.rd),
    .regwrite_w (sh_w_q.regwrite),
    .sel        (fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_e       (rs2_e_q),
    .rd_m       (sh_m_q.rd),
    .regwrite_m (sh_m_q.regwrite),
    .rd_w       (sh_w_q.rd),
    .regwrite_w (sh_w_q.regwrite),
    .sel        (fwd_b)
  );

  assign forward_a_e = fwd_a;
  assign forward_b_e = fwd_b;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (counters built 4 bits wide to reach saturation).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       regwrite_d, load_d, pcsrc_e, mem_busy;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_d, flush_e, stall_emw;
  logic [3:0] stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .load_d(load_d),
    .pcsrc_e(pcsrc_e), .mem_busy(mem_busy),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .stall_emw(stall_emw),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // ctl = {stall_f, stall_d, flush_d, flush_e, stall_emw}
  wire [4:0] ctl = {stall_f, stall_d, flush_d, flush_e, stall_emw};

  task automatic set_d(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic rw, input logic ld);
    rs1_d = r1; rs2_d = r2; rd_d = rd; regwrite_d = rw; load_d = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    pcsrc_e = 0; mem_busy = 0;
    set_d(0, 0, 0, 0, 0);
    rst_n = 0; #3; rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
      regwrite_d = 1'($urandom); load_d = 1'($urandom);
      pcsrc_e = 1'($urandom); mem_busy = 1'($urandom);
      tick();
      total++;
      if ({ctl, forward_a_e, forward_b_e, stall_cnt, flush_cnt} !== 17'd0)
        $display("FAIL reset_outputs[%0d]: got ctl=%b fa=%b fb=%b sc=%0d fc=%0d, want all 0",
                 i, ctl, forward_a_e, forward_b_e, stall_cnt, flush_cnt);
      else passed++;
    end
    pcsrc_e = 0; mem_busy = 0; set_d(0, 0, 0, 0, 0);
    rst_n = 1;
    tick(); tick();
    total++;
    if ({ctl, forward_a_e, forward_b_e, stall_cnt, flush_cnt} !== 17'd0)
      $display("FAIL reset_idle: got ctl=%b fa=%b fb=%b sc=%0d fc=%0d, want all 0",
               ctl, forward_a_e, forward_b_e, stall_cnt, flush_cnt);
    else passed++;
  endtask

  task automatic test_forward();
    do_reset();
    set_d(0, 0, 5, 1, 0);            // add x5
    tick(); set_d(5, 0, 6, 1, 0);    // consumer of x5 (writes x6)
    tick(); set_d(5, 0, 0, 0, 0);    // consumer in E, producer in M
    total++;
    if (forward_a_e !== 2'b10) $display("FAIL fwd_mem: fa=%b want 10", forward_a_e); else passed++;
    total++;
    if (forward_b_e !== 2'b00) $display("FAIL fwd_mem_b: fb=%b want 00", forward_b_e); else passed++;
    tick();                          // second consumer in E, producer in W
    total++;
    if (forward_a_e !== 2'b01) $display("FAIL fwd_wb: fa=%b want 01", forward_a_e); else passed++;
    // Both M and W write x5: MEM wins.
    set_d(0, 0, 5, 1, 0);
    tick(); set_d(0, 0, 5, 1, 0);
    tick(); set_d(0, 5, 0, 0, 0);
    tick(); set_d(0, 0, 0, 0, 0);
    total++;
    if (forward_b_e !== 2'b10) $display("FAIL fwd_prio: fb=%b want 10", forward_b_e); else passed++;
    // x0 never forwards.
    set_d(0, 0, 0, 1, 0);
    tick(); set_d(0, 0, 0, 0, 0);
    tick();
    total++;
    if ({forward_a_e, forward_b_e} !== 4'b0000)
      $display("FAIL fwd_x0: fa=%b fb=%b want 00 00", forward_a_e, forward_b_e);
    else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(0, 0, 7, 1, 1);            // lw x7
    tick(); set_d(1, 7, 8, 1, 0);    // consumer uses rs2 = x7
    total++;
    if (ctl !== 5'b11010) $display("FAIL lu_stall: ctl=%b want 11010", ctl); else passed++;
    tick();                          // bubble in E, D held
    total++;
    if (ctl !== 5'b00000) $display("FAIL lu_release: ctl=%b want 00000", ctl); else passed++;
    total++;
    if (stall_cnt !== 4'd1) $display("FAIL lu_cnt: stall_cnt=%0d want 1", stall_cnt); else passed++;
    tick(); set_d(0, 0, 0, 0, 0);    // consumer in E, load in W
    total++;
    if (forward_b_e !== 2'b01) $display("FAIL lu_fwd_b: fb=%b want 01", forward_b_e); else passed++;
    total++;
    if (forward_a_e !== 2'b00) $display("FAIL lu_fwd_a: fa=%b want 00", forward_a_e); else passed++;
  endtask

  task automatic test_branch_over_lu();
    do_reset();
    set_d(0, 0, 7, 1, 1);
    tick(); set_d(7, 0, 0, 0, 0); pcsrc_e = 1; #1;
    total++;
    if (ctl !== 5'b00110) $display("FAIL br_lu_ctl: ctl=%b want 00110", ctl); else passed++;
    tick(); pcsrc_e = 0; set_d(0, 0, 0, 0, 0);
    total++;
    if (flush_cnt !== 4'd1) $display("FAIL br_flush_cnt: flush_cnt=%0d want 1", flush_cnt); else passed++;
    total++;
    if (stall_cnt !== 4'd0) $display("FAIL br_stall_cnt: stall_cnt=%0d want 0", stall_cnt); else passed++;
  endtask

  task automatic test_mem_busy();
    do_reset();
    set_d(0, 0, 9, 1, 0);            // add x9
    tick(); set_d(9, 0, 0, 0, 0);
    tick();                          // consumer in E, x9 in M
    pcsrc_e = 1; mem_busy = 1; #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ctl !== 5'b11001) $display("FAIL busy_ctl[%0d]: ctl=%b want 11001", i, ctl); else passed++;
      total++;
      if (forward_a_e !== 2'b10) $display("FAIL busy_frozen[%0d]: fa=%b want 10", i, forward_a_e); else passed++;
      tick();
    end
    mem_busy = 0; #1;
    total++;
    if (ctl !== 5'b00110) $display("FAIL busy_drop: ctl=%b want 00110", ctl); else passed++;
    total++;
    if (flush_cnt !== 4'd0) $display("FAIL busy_cnt_hold: flush_cnt=%0d want 0", flush_cnt); else passed++;
    tick(); pcsrc_e = 0; #1;
    total++;
    if (flush_cnt !== 4'd1) $display("FAIL busy_flush_cnt: flush_cnt=%0d want 1", flush_cnt); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      set_d(0, 0, 7, 1, 1);
      tick(); set_d(0, 7, 0, 0, 0);
      tick();
      if (i == 3 || i == 15 || i == 20) begin
        total++;
        if (stall_cnt !== ((i < 15) ? 4'(i) : 4'd15))
          $display("FAIL sat_cnt[%0d]: stall_cnt=%0d want %0d", i, stall_cnt, (i < 15) ? i : 15);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    set_d(0, 0, 7, 1, 1);
    tick(); set_d(7, 0, 0, 0, 0);
    total++;
    if (ctl !== 5'b11010) $display("FAIL mid_pre: ctl=%b want 11010", ctl); else passed++;
    #2 rst_n = 0; #1;
    total++;
    if ({ctl, stall_cnt} !== 9'd0) $display("FAIL mid_reset: ctl=%b sc=%0d want 0 0", ctl, stall_cnt);
    else passed++;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; pcsrc_e = 0; mem_busy = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0; regwrite_d = 0; load_d = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_branch_over_lu();
    test_mem_busy();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
